// File: rtl/exe_muldiv_pkg.sv
// Shared types and RV-M op encodings for the iterative multiply/divide unit.
package exe_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    function automatic logic f3_a_signed(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/exe_muldiv_unit_fwd_mux.sv
// Operand forwarding select: 0 picks the register value, k picks forwarded
// slice k-1, anything beyond the last source yields zero.
module exe_fwd_mux
    import exe_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_FWD      = 2,
    parameter int FSEL_W     = $clog2(N_FWD + 1)
) (
    input  logic [DATA_WIDTH-1:0]       reg_data,
    input  logic [N_FWD*DATA_WIDTH-1:0] fwd_data,
    input  logic [FSEL_W-1:0]           sel,
    output logic [DATA_WIDTH-1:0]       data
);

    always_comb begin
        data = '0;
        if (sel == '0) begin
            data = reg_data;
        end
        for (int k = 1; k <= N_FWD; k++) begin
            if (sel == FSEL_W'(k)) begin
                data = fwd_data[(k-1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative RV-M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up on the final step, zero-divisor/overflow shortcuts.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a new op (in_ready high)
//   ST_CALC | DATA_WIDTH shift-add / restoring-divide iterations
//   ST_DONE | result held on out_valid until out_ready (or flush)
module exe_muldiv_unit
    import exe_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_FWD      = 2,
    parameter int FSEL_W     = $clog2(N_FWD + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  funct3,
    input  logic [DATA_WIDTH-1:0]       rs1_data,
    input  logic [DATA_WIDTH-1:0]       rs2_data,
    input  logic [N_FWD*DATA_WIDTH-1:0] fwd_data,
    input  logic [FSEL_W-1:0]           fwd_sel_a,
    input  logic [FSEL_W-1:0]           fwd_sel_b,
    input  logic [4:0]                  rd_addr_in,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       result,
    output logic [4:0]                  rd_addr_out,
    output logic                        busy
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    muldiv_state_t state, state_d;
    logic          accept, last_step;

    logic [W-1:0] opnd_a, opnd_b;

    exe_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .N_FWD(N_FWD), .FSEL_W(FSEL_W)) u_fwd_a (
        .reg_data (rs1_data),
        .fwd_data (fwd_data),
        .sel      (fwd_sel_a),
        .data     (opnd_a)
    );

    exe_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .N_FWD(N_FWD), .FSEL_W(FSEL_W)) u_fwd_b (
        .reg_data (rs2_data),
        .fwd_data (fwd_data),
        .sel      (fwd_sel_b),
        .data     (opnd_b)
    );

    // Accept-cycle decode: magnitudes, result signs and the two shortcut cases.
    logic         is_div, a_sign, b_sign, div_zero, div_ovf, special;
    logic [W-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_div   = funct3[2];
        a_sign   = opnd_a[W-1] && f3_a_signed(funct3);
        b_sign   = opnd_b[W-1] && f3_b_signed(funct3);
        a_mag    = a_sign ? -opnd_a : opnd_a;
        b_mag    = b_sign ? -opnd_b : opnd_b;
        div_zero = is_div && (opnd_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                   && (opnd_a == {1'b1, {(W-1){1'b0}}}) && (opnd_b == '1);
        special  = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? opnd_a : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : opnd_a;
        end
    end

    // Iteration registers: {acc_hi, acc_lo} is product / {remainder, quotient}.
    logic [W-1:0]     acc_hi, acc_lo, op_m;
    logic [CNT_W-1:0] cnt;
    logic             is_div_q, want_rem_q, sel_hi_q, neg_q, neg_rem_q;
    logic [4:0]       rd_tag_q;
    logic [W-1:0]     result_q;

    logic [W:0]       mul_sum, rem_sh, rem_diff;
    logic [W-1:0]     hi_nx, lo_nx, quo, rem, final_res;
    logic [2*W-1:0]   prod, prod_s;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_m} : '0);
        rem_sh   = {acc_hi, acc_lo[W-1]};
        rem_diff = rem_sh - {1'b0, op_m};
        if (is_div_q) begin
            if (!rem_diff[W]) begin
                hi_nx = rem_diff[W-1:0];
                lo_nx = {acc_lo[W-2:0], 1'b1};
            end else begin
                hi_nx = rem_sh[W-1:0];
                lo_nx = {acc_lo[W-2:0], 1'b0};
            end
        end else begin
            hi_nx = mul_sum[W:1];
            lo_nx = {mul_sum[0], acc_lo[W-1:1]};
        end
        prod   = {hi_nx, lo_nx};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -lo_nx : lo_nx;
        rem    = neg_rem_q ? -hi_nx : hi_nx;
        if (is_div_q) begin
            final_res = want_rem_q ? rem : quo;
        end else begin
            final_res = sel_hi_q ? prod_s[2*W-1:W] : prod_s[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Flush outranks every transition, including accept and completion.
    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!flush && in_valid) begin
                    accept  = 1'b1;
                    state_d = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt == LAST_CNT) begin
                    last_step = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi     <= '0;
            acc_lo     <= '0;
            op_m       <= '0;
            cnt        <= '0;
            is_div_q   <= 1'b0;
            want_rem_q <= 1'b0;
            sel_hi_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            rd_tag_q   <= '0;
            result_q   <= '0;
        end else if (accept) begin
            acc_hi     <= '0;
            acc_lo     <= is_div ? a_mag : b_mag;
            op_m       <= is_div ? b_mag : a_mag;
            cnt        <= '0;
            is_div_q   <= is_div;
            want_rem_q <= funct3[1];
            sel_hi_q   <= |funct3[1:0];
            neg_q      <= a_sign ^ b_sign;
            neg_rem_q  <= a_sign;
            rd_tag_q   <= rd_addr_in;
            if (special) begin
                result_q <= special_res;
            end
        end else if ((state == ST_CALC) && !flush) begin
            acc_hi <= hi_nx;
            acc_lo <= lo_nx;
            cnt    <= last_step ? '0 : cnt + CNT_W'(1);
            if (last_step) begin
                result_q <= final_res;
            end
        end
    end

    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign busy        = (state == ST_CALC) || (state == ST_DONE);
    assign result      = result_q;
    assign rd_addr_out = rd_tag_q;

endmodule

// File: doc/exe_muldiv_unit.md
EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter N_FWD, default 2, number of forwarding sources (MEM, WB, ...).
REQ-003 SHALL have parameter FSEL_W, default $clog2(N_FWD+1), forwarding-select width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  op offered.
REQ-007 SHALL have port in_ready  out  1  unit can accept (state IDLE).
REQ-008 SHALL have port funct3  in  3  RV-M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have port rs1_data, rs2_data  in  DATA_WIDTH each  register-file operands.
REQ-010 SHALL have port fwd_data  in  N_FWD*DATA_WIDTH  forwarded values, source k at slice k.
REQ-011 SHALL have port fwd_sel_a, fwd_sel_b  in  FSEL_W each  0 = register operand, k = fwd_data slice k-1; values >N_FWD select zero.
REQ-012 SHALL have port rd_addr_in  in  5  destination tag.
REQ-013 SHALL have port flush  in  1  kill in-flight op.
REQ-014 SHALL have port out_valid  out  1  result available.
REQ-015 SHALL have port out_ready  in  1  consumer takes result.
REQ-016 SHALL have port result  out  DATA_WIDTH  op result.
REQ-017 SHALL have port rd_addr_out  out  5  tag of result.
REQ-018 SHALL have port busy  out  1  pipeline stall request (state CALC or DONE).

Function
REQ-019 SHALL resolve operands through forwarding muxes combinationally in the accept cycle and latch them on in_valid && in_ready.
REQ-020 SHALL implement FSM IDLE -> CALC on accept; CALC -> DONE after DATA_WIDTH iterations; DONE -> IDLE on out_ready; any state -> IDLE on flush.
REQ-021 SHALL compute one radix-2 step per CALC cycle (shift-add multiply, restoring divide) with a counter 0..DATA_WIDTH-1; out_valid rises exactly DATA_WIDTH+1 cycles after accept.
REQ-022 SHALL sign-handle per funct3: MULH signed x signed, MULHSU signed x unsigned, MULHU/DIVU/REMU unsigned; MUL returns low half, MULH* high half of the 2*DATA_WIDTH product.
REQ-023 SHALL give DIV/REM quotient sign = sign(rs1) xor sign(rs2), remainder sign = sign(rs1).
REQ-024 SHALL on divide-by-zero skip CALC (IDLE -> DONE, out_valid 1 cycle after accept): quotient all-ones, remainder = dividend.
REQ-025 SHALL on signed overflow (most-negative / -1) skip CALC: quotient = dividend, remainder = 0.
REQ-026 SHALL hold result, rd_addr_out, out_valid stable in DONE until out_ready.
REQ-027 SHALL keep in_ready low outside IDLE; no new accept in the cycle DONE -> IDLE.
REQ-028 SHALL give flush priority over accept and completion: flush with in_valid in IDLE accepts nothing; flush in DONE drops the result with no handshake.
REQ-029 SHALL drive out_valid only in DONE.

Reset
REQ-030 SHALL on rst enter IDLE immediately: out_valid 0, busy 0, in_ready 1 after release, result 0, rd_addr_out 0, counter 0, operand registers 0.
REQ-031 SHALL discard any in-flight op when rst asserts mid-CALC or in DONE.

Structure
REQ-032 SHALL place FSM state enum and funct3 op constants in shared package exe_muldiv_pkg.
REQ-033 SHALL implement forwarding selection as one parametrised sub-module exe_fwd_mux (DATA_WIDTH, N_FWD), instantiated twice.

Verification
REQ-034 SHALL cover MUL 6 x 7, sel 0/0 -> result 0x0000002A, out_valid at accept+33.
REQ-035 SHALL cover MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE.
REQ-036 SHALL cover DIV 7 / 0 -> 0xFFFFFFFF and REM 7 / 0 -> 0x00000007, both out_valid at accept+1.
REQ-037 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-038 SHALL cover forwarding: rs1_data 1, fwd slice 1 = 100, fwd_sel_a 2, rs2 5, DIVU -> 20.
REQ-039 SHALL cover flush at CALC cycle 10 -> IDLE next cycle, no out_valid; out_ready low 5 cycles in DONE -> result stable, busy 1.
